msg_sequencer: RTL

- Sequences a combinational character-message ROM (the 4-bit-code string modules such as the "REJEITADO" message), one character at a time.
- Selects one message, drives the ROM character index from 0 up to its length minus 1, and registers each returned code.
- Presents each code to the downstream display writer over a valid/ready handshake, with a programmable inter-character gap and optional loop (scroll) mode.
- Sits between the top-level control FSM (start/abort/select) and the message ROM mux plus display driver.

---
 rtl/msg_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/msg_sequencer.sv
// msg_sequencer: walks a combinational character-message ROM one index at a
// time and hands each registered code to the display writer over valid/ready.
// An optional inter-character gap and a loop mode support scrolling text.
module msg_sequencer #(
  parameter int CHAR_W     = 4,
  parameter int CNT_W      = 4,
  parameter int SEL_W      = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              repeat_en,
  input  logic [SEL_W-1:0]  msg_sel,
  input  logic [CHAR_W-1:0] caracter,
  input  logic [CHAR_W-1:0] len_string,
  output logic [SEL_W-1:0]  sel_out,
  output logic [CNT_W-1:0]  counter_caracter,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              busy,
  output logic              done
);

  // Gap counter only has to hold GAP_CYCLES-1; keep at least one bit so the
  // zero-gap build still elaborates cleanly.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // Index and length may differ in width, so compare them in a common width.
  localparam int CMP_W = (CNT_W > CHAR_W) ? CNT_W : CHAR_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    SEND,
    GAP,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CHAR_W-1:0] len_q, len_d;
  logic              isLast;

  // The last index is judged against the length frozen at LOAD, never the
  // live ROM length, so a ROM change mid-message cannot shorten the walk.
  assign isLast = (CMP_W'(cnt_q) == (CMP_W'(len_q) - CMP_W'(1)));

  // Next-state and next-output logic; abort pre-empts every non-idle state,
  // including a handshake happening in the same cycle.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gap_d   = gap_q;
    len_d   = len_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            sel_d   = msg_sel;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          len_d = len_string;
          if (len_string == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = FETCH;
          end
        end
        FETCH: begin
          char_d  = caracter;
          valid_d = 1'b1;
          state_d = SEND;
        end
        SEND: begin
          if (char_ready) begin
            valid_d = 1'b0;
            if (isLast && !repeat_en) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              cnt_d   = isLast ? '0 : cnt_q + CNT_W'(1);
              gap_d   = GAP_LOAD;
              state_d = (GAP_CYCLES == 0) ? FETCH : GAP;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) begin
            state_d = FETCH;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
    end
  end

  assign sel_out          = sel_q;
  assign counter_caracter = cnt_q;
  assign char_out         = char_q;
  assign char_valid       = valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
